cp_readback_1506: RTL and testbench

CP_READBACK_1506 -- requirements
Module: cp_readback_1506

---
 rtl/cp_readback_1506_if.sv | 31 +++
 rtl/cp_readback_1506.sv | 93 +++++++++
 tb/tb_cp_readback_1506.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cp_readback_1506_if.sv
// Readback bus: host request, wrapper strobe/command/data and output word stream.
// The master side is the host/wrapper; the slave side is the readback block.
interface cp_readback_1506_if #(
    parameter int N = 1506,
    parameter int W = 32
);
    logic         req_valid;
    logic [6:0]   req_addr;
    logic         req_ready;
    logic         get_output;
    logic [23:0]  command_out;
    logic [N-1:0] dout_1;
    logic [N-1:0] dout_2;
    logic         m_valid;
    logic         m_ready;
    logic [W-1:0] m_data;
    logic         m_sel;
    logic         m_last;

    modport master (
        output req_valid, req_addr, dout_1, dout_2, m_ready,
        input  req_ready, get_output, command_out,
        input  m_valid, m_data, m_sel, m_last
    );

    modport slave (
        input  req_valid, req_addr, dout_1, dout_2, m_ready,
        output req_ready, get_output, command_out,
        output m_valid, m_data, m_sel, m_last
    );
endinterface

// File: rtl/cp_readback_1506.sv
// Register-file readback: issues one command strobe, latches both operand
// halves and streams them out as W-bit words, dout_1 first, LSW first.
module cp_readback_1506 #(
    parameter int N      = 1506,
    parameter int W      = 32,
    parameter int RD_LAT = 1
) (
    input logic               clk,
    input logic               rst,
    cp_readback_1506_if.slave bus
);
    localparam int K    = (N + W - 1) / W;
    localparam int KW   = K * W;
    localparam int CW   = $clog2(2 * K);
    localparam int LAST = 2 * K - 1;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        STREAM
    } state_t;

    state_t          state;
    logic [6:0]      addr;
    logic [2:0]      lat;
    logic [CW-1:0]   wcnt;
    logic [2*KW-1:0] data;

    assign bus.req_ready   = (state == IDLE);
    assign bus.get_output  = (state == ISSUE);
    assign bus.command_out = bus.get_output ? {3'b000, addr, 14'b0} : 24'd0;
    // Low word of the shift register is always the word on offer.
    assign bus.m_data      = bus.m_valid ? data[W-1:0] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            lat         <= '0;
            wcnt        <= '0;
            data        <= '0;
            bus.m_valid <= 1'b0;
            bus.m_sel   <= 1'b0;
            bus.m_last  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        addr  <= bus.req_addr;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    lat   <= '0;
                    state <= (RD_LAT == 1) ? CAPTURE : WAIT;
                end
                WAIT: begin
                    lat <= lat + 3'd1;
                    if (lat == 3'(RD_LAT - 2))
                        state <= CAPTURE;
                end
                CAPTURE: begin
                    data        <= {KW'(bus.dout_2), KW'(bus.dout_1)};
                    wcnt        <= '0;
                    bus.m_valid <= 1'b1;
                    bus.m_sel   <= 1'b0;
                    bus.m_last  <= (LAST == 0);
                    state       <= STREAM;
                end
                STREAM: begin
                    if (bus.m_ready) begin
                        if (wcnt == CW'(LAST)) begin
                            wcnt        <= '0;
                            data        <= '0;
                            bus.m_valid <= 1'b0;
                            bus.m_sel   <= 1'b0;
                            bus.m_last  <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            wcnt       <= wcnt + 1'b1;
                            data       <= data >> W;
                            bus.m_sel  <= (wcnt + 1'b1) >= CW'(K);
                            bus.m_last <= (wcnt + 1'b1) == CW'(LAST);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cp_readback_1506.sv
// Directed bench for cp_readback_1506: two instances, RD_LAT=1 and RD_LAT=3.
module tb_cp_readback_1506;
    localparam int N  = 1506;
    localparam int W  = 32;
    localparam int K  = 48;
    localparam int KW = K * W;

    logic clk;
    logic rst;
    int   cyc;
    int   errors;
    int   checks;

    logic [W-1:0] got_data [0:199];
    logic         got_sel  [0:199];
    logic         got_last [0:199];
    int           n_got;

    cp_readback_1506_if #(.N(N), .W(W)) a ();
    cp_readback_1506_if #(.N(N), .W(W)) b ();

    cp_readback_1506 #(.N(N), .W(W), .RD_LAT(1)) u_a (
        .clk(clk),
        .rst(rst),
        .bus(a)
    );

    cp_readback_1506 #(.N(N), .W(W), .RD_LAT(3)) u_b (
        .clk(clk),
        .rst(rst),
        .bus(b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] rnd();
        logic [KW-1:0] t;
        for (int i = 0; i < K; i++) t[i*W +: W] = $urandom;
        return t[N-1:0];
    endfunction

    function automatic logic [W-1:0] wexp(input logic [N-1:0] d, input int i);
        logic [KW-1:0] x;
        x = '0;
        x[N-1:0] = d;
        return x[i*W +: W];
    endfunction

    // mode 0: m_ready=1; 1: m_ready 1,0,0,1; 2: m_ready=1 and dout scrambled after capture
    task automatic do_read(input string tag, input logic [6:0] addr,
                           input logic [N-1:0] d1, input logic [N-1:0] d2,
                           input int mode, input int rst_at);
        int t0, tfirst, tlast, gp, idx;
        logic stall, done, ps, pl;
        logic [W-1:0] pd;
        logic [23:0] cmd;
        n_got = 0; gp = 0; tfirst = -1; tlast = -1;
        stall = 1'b0; done = 1'b0; cmd = '0; ps = 1'b0; pl = 1'b0; pd = '0;
        check({tag, "_req_ready"}, a.req_ready, 1);
        a.req_valid = 1'b1;
        a.req_addr  = addr;
        a.dout_1    = d1;
        a.dout_2    = d2;
        a.m_ready   = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 1000 && !done; k++) begin
            @(posedge clk); #1;
            a.req_valid = 1'b0;
            if (a.get_output) begin
                gp++;
                cmd = a.command_out;
            end
            if (stall)
                check({tag, "_stall_hold"}, {a.m_valid, a.m_sel, a.m_last, a.m_data},
                      {1'b1, ps, pl, pd});
            if (!a.m_valid)
                check({tag, "_idle_data"}, a.m_data, 0);
            if (a.m_valid && tfirst < 0)
                tfirst = cyc;
            if (mode == 2 && tfirst >= 0) begin
                a.dout_1 = rnd();
                a.dout_2 = rnd();
            end
            if (mode == 1) begin
                idx = (cyc - t0) % 4;
                a.m_ready = (idx == 0 || idx == 3);
            end
            if (rst_at >= 0 && n_got == rst_at && a.m_valid) begin
                rst = 1'b1;
                a.m_ready = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                a.m_ready = 1'b1;
                check({tag, "_rst_valid"}, a.m_valid, 0);
                check({tag, "_rst_ready"}, a.req_ready, 1);
                return;
            end
            stall = a.m_valid && !a.m_ready;
            pd = a.m_data; ps = a.m_sel; pl = a.m_last;
            if (a.m_valid && a.m_ready) begin
                got_data[n_got] = a.m_data;
                got_sel[n_got]  = a.m_sel;
                got_last[n_got] = a.m_last;
                n_got++;
                if (a.m_last) begin
                    tlast = cyc;
                    done = 1'b1;
                end
            end
        end
        a.m_ready = 1'b1;
        check({tag, "_complete"}, done, 1);
        check({tag, "_gp_count"}, gp, 1);
        check({tag, "_command"}, cmd, {3'b000, addr, 14'b0});
        check({tag, "_nwords"}, n_got, 2 * K);
        check({tag, "_first_lat"}, tfirst - t0, 3);
        if (mode != 1)
            check({tag, "_last_lat"}, tlast - t0, 98);
        for (int i = 0; i < n_got && i < 2 * K; i++)
            check($sformatf("%s_w%0d", tag, i), {got_sel[i], got_last[i], got_data[i]},
                  {i >= K, i == 2 * K - 1, (i < K) ? wexp(d1, i) : wexp(d2, i - K)});
        @(posedge clk); #1;
        check({tag, "_end_ready"}, a.req_ready, 1);
        check({tag, "_end_valid"}, a.m_valid, 0);
    endtask

    initial begin
        logic [N-1:0] v1, v2;
        int acc [0:1];
        int nacc, tf, tl, nx;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        a.req_valid = 1'b0; a.req_addr = '0; a.m_ready = 1'b0;
        a.dout_1 = '0; a.dout_2 = '0;
        b.req_valid = 1'b0; b.req_addr = '0; b.m_ready = 1'b0;
        b.dout_1 = '0; b.dout_2 = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_req_ready", a.req_ready, 1);
        check("rst_get_output", a.get_output, 0);
        check("rst_command", a.command_out, 0);
        check("rst_stream", {a.m_valid, a.m_last, a.m_sel, a.m_data}, 0);
        check("rst_b_ready", b.req_ready, 1);
        check("rst_b_valid", b.m_valid, 0);

        v1 = '0; v1[0] = 1'b1;
        v2 = '0; v2[N-1] = 1'b1;
        do_read("basic", 7'd0, v1, v2, 0, -1);
        check("basic_word0", {got_sel[0], got_last[0], got_data[0]}, {1'b0, 1'b0, 32'h1});
        check("basic_word47", got_data[47], 0);
        check("basic_word95", {got_sel[95], got_last[95], got_data[95]}, {1'b1, 1'b1, 32'h2});

        v1 = '1;
        v2 = '0;
        for (int i = 0; i < N; i += 3) v2[i] = 1'b1;
        do_read("addr1", 7'd1, v1, v2, 0, -1);
        check("addr1_top_word", got_data[47], 32'h3);
        check("addr1_w48", got_data[48], 32'h49249249);
        do_read("addr3", 7'd3, rnd(), rnd(), 0, -1);
        do_read("addr5", 7'd5, rnd(), rnd(), 0, -1);

        do_read("bp", 7'd9, rnd(), rnd(), 1, -1);
        do_read("iso", 7'd127, rnd(), rnd(), 2, -1);

        do_read("rst40", 7'd2, rnd(), rnd(), 0, 40);
        repeat (2) begin
            @(posedge clk); #1;
            check("rst40_quiet", a.m_valid, 0);
        end
        do_read("after_rst", 7'd4, rnd(), rnd(), 0, -1);

        b.dout_1 = rnd();
        b.dout_2 = rnd();
        b.m_ready = 1'b1;
        b.req_addr = 7'd6;
        b.req_valid = 1'b1;
        nacc = 0; tf = -1; tl = -1; nx = 0;
        acc[0] = 0; acc[1] = 0;
        for (int k = 0; k < 400; k++) begin
            if (b.req_valid && b.req_ready) begin
                acc[nacc] = cyc;
                nacc++;
            end
            if (nacc == 2) break;
            if (b.m_valid && tf < 0) tf = cyc;
            if (b.m_valid && b.m_ready) begin
                nx++;
                if (b.m_last) tl = cyc;
            end
            @(posedge clk); #1;
        end
        check("b2b_accepts", nacc, 2);
        check("b2b_first_lat", tf - acc[0], 5);
        check("b2b_words", nx, 2 * K);
        check("b2b_reaccept", acc[1] - tl, 1);
        b.req_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
